// File: rtl/frame_buffer_pkg.sv
// Shared sizing helpers and pixel type for the streaming row buffer and its banks.
package frame_buffer_pkg;

    localparam int DEFAULT_PIXEL_DEPTH = 24;

    typedef logic [DEFAULT_PIXEL_DEPTH-1:0] pixel_t;

    // Widths never collapse to zero so degenerate sizes still elaborate.
    function automatic int col_width(input int columns);
        return (columns > 1) ? $clog2(columns) : 1;
    endfunction

    function automatic int slot_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/row_bank.sv
// One row of pixel storage: synchronous write, asynchronous read.
module row_bank
    import frame_buffer_pkg::*;
#(
    parameter int P_COLUMNS     = 640,
    parameter int P_PIXEL_DEPTH = 24
) (
    input  logic                             clk,
    input  logic                             write_enable,
    input  logic [col_width(P_COLUMNS)-1:0]  write_addr,
    input  logic [P_PIXEL_DEPTH-1:0]         write_data,
    input  logic [col_width(P_COLUMNS)-1:0]  read_addr,
    output logic [P_PIXEL_DEPTH-1:0]         read_data
);

    logic [P_PIXEL_DEPTH-1:0] mem [P_COLUMNS];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/rolling_row_buffer.sv
// Keeps the last P_ROWS rows in rotating banks and emits one vertical window column
// per accepted pixel once enough rows have been seen.
module rolling_row_buffer
    import frame_buffer_pkg::*;
#(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 3,
    parameter int P_PIXEL_DEPTH = 24
) (
    input  logic                              I_CLK,
    input  logic                              I_RESET,
    input  logic [P_PIXEL_DEPTH-1:0]          I_PIXEL,
    input  logic                              I_VALID,
    input  logic                              I_SOF,
    output logic                              O_READY,
    output logic [P_ROWS*P_PIXEL_DEPTH-1:0]   O_COLUMN,
    output logic [col_width(P_COLUMNS)-1:0]   O_COLUMN_INDEX,
    output logic                              O_EOL,
    output logic                              O_VALID,
    input  logic                              I_READY
);

    localparam int CW = col_width(P_COLUMNS);
    localparam int SW = slot_width(P_ROWS);
    localparam logic [CW-1:0] LAST_COL  = CW'(P_COLUMNS - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(P_ROWS - 1);

    logic [CW-1:0]                    col, col_eff;
    logic [SW-1:0]                    slot, slot_eff;
    logic [SW-1:0]                    rows_filled, filled_eff;
    logic                             accept;
    logic [P_PIXEL_DEPTH-1:0]         bank_rdata [P_ROWS];
    logic [P_ROWS*P_PIXEL_DEPTH-1:0]  column_next;

    assign O_READY = !I_RESET && (!O_VALID || I_READY);
    assign accept  = I_VALID && O_READY;

    // A start-of-frame pixel behaves as if the position counters were already cleared.
    assign col_eff    = I_SOF ? '0 : col;
    assign slot_eff   = I_SOF ? '0 : slot;
    assign filled_eff = I_SOF ? '0 : rows_filled;

    for (genvar i = 0; i < P_ROWS; i++) begin : g_bank
        row_bank #(
            .P_COLUMNS     (P_COLUMNS),
            .P_PIXEL_DEPTH (P_PIXEL_DEPTH)
        ) u_bank (
            .clk          (I_CLK),
            .write_enable (accept && (slot_eff == SW'(i))),
            .write_addr   (col_eff),
            .write_data   (I_PIXEL),
            .read_addr    (col_eff),
            .read_data    (bank_rdata[i])
        );
    end

    // Walk backwards through the slot ring so older rows land in higher slices.
    always_comb begin
        column_next = '0;
        column_next[P_PIXEL_DEPTH-1:0] = I_PIXEL;
        for (int k = 1; k < P_ROWS; k++) begin
            logic [SW-1:0] src;
            src = (slot_eff >= SW'(k)) ? (slot_eff - SW'(k)) : (slot_eff + SW'(P_ROWS - k));
            column_next[k*P_PIXEL_DEPTH +: P_PIXEL_DEPTH] = bank_rdata[src];
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            col            <= '0;
            slot           <= '0;
            rows_filled    <= '0;
            O_VALID        <= 1'b0;
            O_COLUMN       <= '0;
            O_COLUMN_INDEX <= '0;
            O_EOL          <= 1'b0;
        end else if (accept) begin
            if (filled_eff == LAST_SLOT) begin
                O_COLUMN       <= column_next;
                O_COLUMN_INDEX <= col_eff;
                O_EOL          <= (col_eff == LAST_COL);
                O_VALID        <= 1'b1;
            end else begin
                O_VALID        <= 1'b0;
            end
            if (col_eff == LAST_COL) begin
                col         <= '0;
                slot        <= (slot_eff == LAST_SLOT) ? '0 : slot_eff + 1'b1;
                rows_filled <= (filled_eff == LAST_SLOT) ? filled_eff : filled_eff + 1'b1;
            end else begin
                col         <= col_eff + 1'b1;
                slot        <= slot_eff;
                rows_filled <= filled_eff;
            end
        end else if (I_READY) begin
            O_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rolling_row_buffer.sv
// Scoreboard bench: a frame-level image model predicts every window column, a monitor
// pops and compares whenever the DUT hands one downstream.
module tb_rolling_row_buffer;
    import frame_buffer_pkg::*;

    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int DEPTH = 24;
    localparam int CW    = 2;
    localparam int OW    = ROWS * DEPTH;

    typedef struct {
        logic [OW-1:0] column;
        logic [CW-1:0] index;
        logic          eol;
    } expect_t;

    logic            I_CLK = 1'b0;
    logic            I_RESET = 1'b1;
    logic [DEPTH-1:0] I_PIXEL = '0;
    logic            I_VALID = 1'b0;
    logic            I_SOF = 1'b0;
    logic            O_READY;
    logic [OW-1:0]   O_COLUMN;
    logic [CW-1:0]   O_COLUMN_INDEX;
    logic            O_EOL;
    logic            O_VALID;
    logic            I_READY = 1'b0;

    int checks_done   = 0;
    int checks_failed = 0;

    expect_t exp_q[$];
    pixel_t  img[int];
    int      m_row = 0;
    int      m_col = 0;

    rolling_row_buffer #(
        .P_COLUMNS     (COLS),
        .P_ROWS        (ROWS),
        .P_PIXEL_DEPTH (DEPTH)
    ) dut (
        .I_CLK          (I_CLK),
        .I_RESET        (I_RESET),
        .I_PIXEL        (I_PIXEL),
        .I_VALID        (I_VALID),
        .I_SOF          (I_SOF),
        .O_READY        (O_READY),
        .O_COLUMN       (O_COLUMN),
        .O_COLUMN_INDEX (O_COLUMN_INDEX),
        .O_EOL          (O_EOL),
        .O_VALID        (O_VALID),
        .I_READY        (I_READY)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic checkOutput(input string name, input logic [OW-1:0] actual, input logic [OW-1:0] expected);
        checks_done++;
        if (actual !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Image model: pixels sit at absolute (row, col) of the current frame.
    task automatic modelAccept(input pixel_t pix, input logic sof);
        expect_t e;
        if (sof) begin
            img.delete();
            m_row = 0;
            m_col = 0;
        end
        img[m_row * COLS + m_col] = pix;
        if (m_row >= ROWS - 1) begin
            for (int k = 0; k < ROWS; k++)
                e.column[k*DEPTH +: DEPTH] = img[(m_row - k) * COLS + m_col];
            e.index = CW'(m_col);
            e.eol   = (m_col == COLS - 1);
            exp_q.push_back(e);
        end
        m_col++;
        if (m_col == COLS) begin
            m_col = 0;
            m_row++;
        end
    endtask

    task automatic applyStimulus(input pixel_t pix, input logic valid, input logic sof,
                                 input logic ready, output logic accepted);
        @(negedge I_CLK);
        I_PIXEL = pix;
        I_VALID = valid;
        I_SOF   = sof;
        I_READY = ready;
        #4;
        accepted = valid && (O_READY === 1'b1);
        if (accepted) modelAccept(pix, sof);
    endtask

    task automatic sendPixel(input pixel_t pix, input logic sof);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++)
            applyStimulus(pix, 1'b1, sof, 1'b1, acc);
        if (!acc) checkOutput("send_timeout", OW'(0), OW'(1));
    endtask

    task automatic applyReset(input int cycles);
        @(negedge I_CLK);
        I_RESET = 1'b1;
        I_VALID = 1'b0;
        I_SOF   = 1'b0;
        I_READY = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #4;
            checkOutput("reset_ready", OW'(O_READY), OW'(0));
            @(posedge I_CLK);
            #1;
            checkOutput("reset_valid", OW'(O_VALID), OW'(0));
            checkOutput("reset_column", O_COLUMN, OW'(0));
            checkOutput("reset_index", OW'(O_COLUMN_INDEX), OW'(0));
            checkOutput("reset_eol", OW'(O_EOL), OW'(0));
            @(negedge I_CLK);
        end
        I_RESET = 1'b0;
        I_READY = 1'b1;
        exp_q.delete();
        img.delete();
        m_row = 0;
        m_col = 0;
        #4;
        checkOutput("ready_after_reset", OW'(O_READY), OW'(1));
    endtask

    // Monitor: an output is consumed at an edge where it is valid and downstream is ready.
    initial begin
        expect_t e;
        forever begin
            @(negedge I_CLK);
            #4;
            if (O_VALID === 1'b1 && I_READY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", O_COLUMN, OW'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("column", O_COLUMN, e.column);
                    checkOutput("column_index", OW'(O_COLUMN_INDEX), OW'(e.index));
                    checkOutput("eol", OW'(O_EOL), OW'(e.eol));
                end
            end
        end
    end

    initial begin
        logic acc;
        applyReset(2);

        // Prime with three rows, then wrap into a fourth.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < COLS; c++)
                sendPixel(pixel_t'(r * 16 + c), (r == 0 && c == 0));
        sendPixel(24'h30, 1'b0);
        sendPixel(24'h31, 1'b0);

        // Downstream stall: the held column must not move and no pixel is taken.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(24'h32, 1'b1, 1'b0, 1'b0, acc);
            checkOutput("stall_ready", OW'(O_READY), OW'(0));
            checkOutput("stall_valid", OW'(O_VALID), OW'(1));
            checkOutput("stall_column", O_COLUMN, {24'h11, 24'h21, 24'h31});
            checkOutput("stall_index", OW'(O_COLUMN_INDEX), OW'(1));
        end
        sendPixel(24'h32, 1'b0);
        sendPixel(24'h33, 1'b0);
        sendPixel(24'h40, 1'b0);
        sendPixel(24'h41, 1'b0);

        // Frame restart in the middle of a line.
        sendPixel(24'hAA, 1'b1);
        for (int c = 1; c < COLS; c++) sendPixel(pixel_t'(c), 1'b0);
        for (int c = 0; c < COLS; c++) sendPixel(pixel_t'(16 + c), 1'b0);
        sendPixel(24'h20, 1'b0);
        sendPixel(24'h21, 1'b0);

        // Reset while an output is pending, then re-prime without a start-of-frame.
        applyReset(1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < COLS; c++)
                sendPixel(pixel_t'(8'h50 + r * 16 + c), 1'b0);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(pixel_t'($urandom & 32'h00FF_FFFF),
                          $urandom_range(0, 3) != 0,
                          (i == 0) || ($urandom_range(0, 39) == 0),
                          $urandom_range(0, 3) != 0, acc);
        end

        for (int t = 0; t < 50 && exp_q.size() != 0; t++)
            applyStimulus('0, 1'b0, 1'b0, 1'b1, acc);
        checkOutput("drain_empty", OW'(exp_q.size()), OW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule

// File: doc/rolling_row_buffer.md
Name: rolling_row_buffer

Overview:
- Streaming successor to the random-access frame buffer for the edge-detection pipeline.
- Accepts pixels in raster order over a valid/ready handshake and keeps the last P_ROWS rows in circular row banks.
- For every accepted pixel, once primed, emits one vertical column of P_ROWS vertically aligned pixels, oldest row at the top, to feed the downstream 3x3 kernel window.
- Sits between colorspace conversion and the convolution/window stage.

Parameters:
- P_COLUMNS, 640: pixels per row.
- P_ROWS, 3: rows held, equal to the window height; must be >= 2.
- P_PIXEL_DEPTH, 24: bits per pixel.

Ports:
- I_CLK  input  1  clock.
- I_RESET  input  1  synchronous, active-high reset.
- I_PIXEL  input  P_PIXEL_DEPTH  incoming pixel.
- I_VALID  input  1  I_PIXEL valid.
- I_SOF  input  1  start of frame; qualified by I_VALID.
- O_READY  output  1  block can accept a pixel this cycle.
- O_COLUMN  output  P_ROWS*P_PIXEL_DEPTH  window column; bits [P_PIXEL_DEPTH-1:0] hold the newest row, the top slice holds the oldest row.
- O_COLUMN_INDEX  output  $clog2(P_COLUMNS)  column of O_COLUMN.
- O_EOL  output  1  O_COLUMN is the last column of its row.
- O_VALID  output  1  O_COLUMN, O_COLUMN_INDEX and O_EOL are valid.
- I_READY  input  1  downstream accepts the output.

Behaviour:
- Clocking and reset: one clock, I_CLK. I_RESET is synchronous and active-high.
- Reset values: O_VALID=0, O_COLUMN=0, O_COLUMN_INDEX=0, O_EOL=0. Internal col=0, slot=0, rows_filled=0.
- Bank contents are not cleared by reset. Stale data is never emitted because of priming.
- O_READY is combinational: !I_RESET && (!O_VALID || I_READY).
- Accept: accept = I_VALID && O_READY. With no accept, no state changes and the output register holds its value.
- Effective position on accept:
  - If I_SOF=1, force col=0, slot=0, rows_filled=0 for this pixel. This abandons any partial line or frame.
  - Otherwise use the current col and slot.
- Bank update on accept: I_PIXEL is written into bank[slot] at col.
- Column assembly on accept:
  - Bottom slice = I_PIXEL.
  - Slice k (k=1..P_ROWS-1, counting upward) = bank[(slot-k) mod P_ROWS][col], read before the write.
- Output register, 1-cycle latency:
  - If rows_filled==P_ROWS-1, load O_COLUMN, O_COLUMN_INDEX=col, O_EOL=(col==P_COLUMNS-1), and set O_VALID=1.
  - Else set O_VALID=0. The unprimed pixel is stored only.
  - With no accept, O_VALID clears when I_READY=1, otherwise holds.
- Counter advance after accept:
  - col wraps at P_COLUMNS-1 to 0.
  - On wrap: slot advances mod P_ROWS, and rows_filled increments, saturating at P_ROWS-1.
- Simultaneous accept and output consumption in the same cycle gives full throughput, one pixel per clock.
- I_SOF on the first pixel after reset is legal and has no extra effect.
- I_RESET mid-stream: outputs return to reset values next edge. The next frame re-primes from scratch.
- I_SOF without I_VALID is ignored.

Decomposition:
- Package frame_buffer_pkg holds:
  - localparam-style functions/constants for column-index width and slot width (clog2 of P_COLUMNS and P_ROWS);
  - a typedef for the pixel vector.
- Sub-module row_bank:
  - P_COLUMNS x P_PIXEL_DEPTH storage, synchronous write, asynchronous read.
  - Instantiated P_ROWS times via generate.
- Top level holds counters, the slot-rotation mux, the output register and the handshake.

Test Plan:
All scenarios use P_COLUMNS=4, P_ROWS=3, P_PIXEL_DEPTH=24, and pixel value = row*0x10 + col.
- Reset: I_RESET=1 for 2 cycles -> O_VALID=0, O_COLUMN=0, O_READY=0 during reset; O_READY=1 the cycle after release.
- Priming and first output:
  - Stream rows 0 and 1 (I_SOF on the first pixel) -> O_VALID stays 0.
  - Row 2 col 0 -> next cycle O_VALID=1, O_COLUMN={0x000000,0x000010,0x000020}, index 0.
  - Row 2 col 3 -> O_EOL=1.
- Circular wrap: row 3 col 1 -> O_COLUMN={0x000011,0x000021,0x000031}, index 1, O_EOL=0.
- Backpressure:
  - Hold I_READY=0 while O_VALID=1 and drive I_VALID=1 with 0x000032 -> O_READY=0, output stable, pixel not written.
  - Release I_READY -> the pixel is accepted and the next output has index 2.
- Mid-line frame restart: after row 4 col 1, assert I_SOF with pixel 0x0000AA -> no O_VALID until the third row of the new frame; the first output is {0x0000AA, row1 col0, row2 col0} of the new frame, with no old-frame data.
- Reset mid-stream: assert I_RESET while O_VALID=1 -> O_VALID=0 next edge; the restream requires a full 2-row priming before output.
